// File: rtl/load_store_unit.sv
// RISC-V data-memory access stage: one valid/ready bus transaction per request,
// with byte lanes, store-data replication, load extension and error reporting.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;

  logic          bad_req;
  logic [3:0]    be_req;
  logic [31:0]   wdata_req;
  logic [31:0]   load_data;
  logic          timed_out;
  logic          bus_done;

  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign mem_valid = (state == BUS);
  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1)) && !mem_ready;
  assign bus_done  = mem_ready || timed_out;

  // Request decode: legality, lane enables and replicated store data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    bad_req   = 1'b0;
    be_req    = 4'b0000;
    wdata_req = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        be_req  = 4'b0001 << req_addr[1:0];
        bad_req = req_we && req_funct3[2];
      end
      3'b001, 3'b101: begin
        be_req  = req_addr[1] ? 4'b1100 : 4'b0011;
        bad_req = req_addr[0] || (req_we && req_funct3[2]);
      end
      3'b010: begin
        be_req  = 4'b1111;
        bad_req = (req_addr[1:0] != 2'b00);
      end
      default: bad_req = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00:   wdata_req = {4{req_wdata[7:0]}};
      2'b01:   wdata_req = {2{req_wdata[15:0]}};
      default: wdata_req = req_wdata;
    endcase
  end

  always_comb begin
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    lbyte = mem_rdata[8*lo_q +: 8];
    lhalf = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{lbyte[7]}}, lbyte};
      3'b100:  load_data = {24'h0, lbyte};
      3'b001:  load_data = {{16{lhalf[15]}}, lhalf};
      3'b101:  load_data = {16'h0, lhalf};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = bad_req ? RESP : BUS;
      BUS:     if (bus_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          lo_q <= req_addr[1:0];
          cnt  <= '0;
          if (bad_req) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            mem_we    <= req_we;
            mem_be    <= be_req;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= wdata_req;
          end
        end
        BUS: if (bus_done) begin
          rsp_valid <= 1'b1;
          rsp_err   <= !mem_ready || mem_err;
          rsp_rdata <= (mem_ready && !mem_err && !we_q) ? load_data : 32'h0;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
          mem_addr  <= 32'h0;
          mem_wdata <= 32'h0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses into a
// scoreboard, a negedge monitor pops and compares them as the DUT responds.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_we;
  logic        mem_ready = 1'b0, mem_err = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Presents one request and returns the cycle index of the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int c0);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    check("req_ready_idle", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    c0 = cyc;
    req_valid = 1'b0;
    check("req_ready_busy", {31'h0, req_ready}, 32'd0);
  endtask

  // delay < 0 means never assert mem_ready (timeout path).
  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] bus_rdata, input logic bus_err, input int delay,
                       input logic exp_bus, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int   c0;
    exp_t e;
    issue(we, f3, addr, wdata, c0);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = !exp_bus ? c0 : (delay < 0 ? c0 + T : c0 + delay + 1);
    sb.push_back(e);
    check({name, "_mem_valid"}, {31'h0, mem_valid}, {31'h0, exp_bus});
    if (exp_bus) begin
      check({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({name, "_mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
      check({name, "_mem_we"}, {31'h0, mem_we}, {31'h0, we});
      if (we) check({name, "_mem_wdata"}, mem_wdata, exp_wdata);
      if (delay < 0) begin
        for (int i = 1; i <= T; i++) begin
          @(posedge clk);
          #1;
          check({name, "_to_valid"}, {31'h0, mem_valid}, {31'h0, (i < T)});
        end
      end else begin
        repeat (delay) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = bus_rdata; mem_err = bus_err;
        @(posedge clk);
        #1;
        mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        check({name, "_valid_drop"}, {31'h0, mem_valid}, 32'd0);
        check({name, "_addr_clear"}, mem_addr, 32'h0);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int c0;
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'd0);
    check("rst_outputs", {rsp_valid, rsp_err, mem_valid, mem_we, busy, mem_be},
          32'h0);
    check("rst_rdata", rsp_rdata | mem_addr | mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", {31'h0, req_ready}, 32'd1);

    // mem_ready while idle must be ignored (monitor flags any stray response).
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ready = 1'b0; mem_rdata = 32'h0;

    //     name   we    f3      addr          wdata          bus_rdata     berr dly bus  be       exp_wdata      exp_rdata     err
    do_op("lb",   1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1'b0, 0, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
    do_op("lhu",  1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 1'b0, 0, 1'b1, 4'b1100, 32'h0,         32'h0000_8001, 1'b0);
    do_op("lh",   1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 1'b0, 1, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
    do_op("lh_lo",1'b0, 3'b001, 32'h0000_2000, 32'h0,         32'h8001_7FFF, 1'b0, 0, 1'b1, 4'b0011, 32'h0,         32'h0000_7FFF, 1'b0);
    do_op("sb",   1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h5555_5555, 1'b0, 0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0,         1'b0);
    do_op("sh",   1'b1, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0);
    do_op("sw",   1'b1, 3'b010, 32'h0000_9004, 32'h0102_0304, 32'h0,         1'b0, 0, 1'b1, 4'b1111, 32'h0102_0304, 32'h0,         1'b0);
    do_op("lbu",  1'b0, 3'b100, 32'h0000_7001, 32'h0,         32'h0000_A500, 1'b0, 2, 1'b1, 4'b0010, 32'h0,         32'h0000_00A5, 1'b0);
    do_op("lw",   1'b0, 3'b010, 32'h0000_8000, 32'h0,         32'hCAFE_F00D, 1'b0, 1, 1'b1, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0);
    do_op("lw_mis",1'b0,3'b010, 32'h0000_4002, 32'h0,         32'h0,         1'b0, 0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1);
    do_op("sbu",  1'b1, 3'b100, 32'h0000_4000, 32'h1111_1111, 32'h0,         1'b0, 0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1);
    do_op("f3_011",1'b0,3'b011, 32'h0000_4000, 32'h0,         32'h0,         1'b0, 0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1);
    do_op("lhu_mis",1'b0,3'b101,32'h0000_2001, 32'h0,         32'h0,         1'b0, 0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1);
    do_op("tmo",  1'b0, 3'b010, 32'h0000_5000, 32'h0,         32'h0,         1'b0,-1, 1'b1, 4'b1111, 32'h0,         32'h0,         1'b1);
    do_op("berr", 1'b0, 3'b010, 32'h0000_6004, 32'h0,         32'h1234_5678, 1'b1, 0, 1'b1, 4'b1111, 32'h0,         32'h0,         1'b1);

    // Reset in the middle of a bus cycle abandons the op without a response.
    issue(1'b0, 3'b010, 32'h0000_A000, 32'h0, c0);
    check("rst_mid_valid_before", {31'h0, mem_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, mem_valid}, 32'd0);
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    check("rst_mid_ready", {31'h0, req_ready}, 32'd0);
    check("rst_mid_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release", {31'h0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);

    do_op("post_rst", 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 1'b0, 0, 1'b1, 4'b0001, 32'h0, 32'h0000_007F, 1'b0);

    repeat (4) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage sitting directly downstream of the ALU in the RISC-V datapath. It takes the ALU result as the effective address plus the rs2 store data and the instruction funct3. It then runs one valid/ready transaction on the data-memory bus, with byte-lane enables and store-data replication, and returns sign- or zero-extended load data or a store completion to writeback. Misaligned accesses, illegal funct3 values, bus errors and bus timeouts are reported as a response error, never as a hang.

## Interface
- TIMEOUT, 255: cycles `mem_valid` may wait for `mem_ready` before aborting; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a memory op; held with its fields stable until accepted
- req_ready  out  1  unit can accept; high only in IDLE with `rst_n` high
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address (ALU Result)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors; held until next response
- rsp_err  out  1  valid with `rsp_valid`
- busy  out  1  state != IDLE; used as the core stall
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts/completes in the cycle sampled
- mem_we  out  1  write strobe
- mem_be  out  4  byte-lane enables
- mem_addr  out  32  `{addr[31:2], 2'b00}`
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with `mem_ready`
- mem_err  in  1  bus error, valid with `mem_ready`

## Operation
- FSM states:
  - IDLE: `req_ready` = 1. When `req_valid` is high, latch we/funct3/addr/wdata. Go to RESP if the access is invalid, otherwise go to BUS.
  - BUS: `mem_valid` = 1 and the cycle counter increments.
    - `mem_ready` high: capture data and `mem_err`, go to RESP.
    - Counter reaches TIMEOUT without `mem_ready`: set err, go to RESP.
  - RESP: `rsp_valid` = 1 for exactly one cycle, then go to IDLE.
- Invalid accesses (no bus cycle is issued):
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` != 0.
  - funct3 011, 110 or 111.
  - Store with BU or HU.
- Lane enables:
  - B/BU: `1 << addr[1:0]`.
  - H/HU: 0011 if `addr[1]` = 0, else 1100.
  - W: 1111.
  - Loads drive the same `mem_be`.
- Store data: byte replicated ×4 for B; halfword ×2 for H; word unchanged.
- Load extraction: byte `rdata[8*a+7:8*a]` with `a = addr[1:0]`, or halfword at `addr[1]`.
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- Any error forces `rsp_rdata` = 0 and `rsp_err` = 1.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are registered and stable for the whole BUS state; they are 0 outside BUS.
- Counter: width clog2(TIMEOUT+1), cleared on entry to BUS. Timeout fires on the TIMEOUT-th edge in BUS with `mem_ready` low.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = IDLE, counter = 0.
  - `rsp_valid`, `rsp_err`, `mem_valid`, `mem_we`, `busy` = 0.
  - `rsp_rdata`, `mem_be`, `mem_addr`, `mem_wdata` = 0.
  - `req_ready` = 0 while `rst_n` is low, 1 after release.
- Accept at edge E0; `mem_valid` is high from E0.
- `mem_ready` sampled high at edge Ek: `rsp_valid` is high in the cycle after Ek, and `mem_valid` drops at Ek.
  - Minimum request-to-response latency is 2 edges.
- Invalid access: `rsp_valid` in the cycle after E0, with no `mem_valid`.
- Timeout: with `mem_valid` rising at E0, `mem_valid` falls and the response is given after edge E0+TIMEOUT.
- `req_ready` is low from E0 until the cycle after RESP, so there are no back-to-back accepts. Throughput is at most one op per 3 cycles.
- `mem_ready` high outside BUS is ignored.
- Reset asserted mid-transaction: `mem_valid` drops immediately and no response is issued for the abandoned op.

## Test plan
- LB at 0x1003 with `mem_rdata` = 0x80FF_1234 and `mem_ready` immediate:
  - `mem_addr` = 0x1000, `mem_be` = 1000.
  - `rsp_rdata` = 0xFFFF_FF80, `rsp_err` = 0, `rsp_valid` 2 edges after accept.
- LHU at 0x2002 with `mem_rdata` = 0x8001_7FFF → `rsp_rdata` = 0x0000_8001. LH with the same inputs → 0xFFFF_8001.
- SB at 0x3001 with `req_wdata` = 0x1234_56AB → `mem_we` = 1, `mem_be` = 0010, `mem_wdata` = 0xABAB_ABAB, `rsp_rdata` = 0.
- SH at 0x3002 with wdata 0xDEAD_BEEF → `mem_be` = 1100, `mem_wdata` = 0xBEEF_BEEF.
- Error accesses:
  - LW at 0x4002 → no `mem_valid`; `rsp_valid` and `rsp_err` = 1 one cycle after accept.
  - Store with funct3 100 → same result.
- Timeout, bus error and reset:
  - TIMEOUT = 4 with `mem_ready` held low → `mem_valid` high for exactly 4 cycles, then `rsp_err` = 1.
  - `mem_ready` with `mem_err` = 1 → `rsp_err` = 1, `rsp_rdata` = 0.
  - `rst_n` pulsed low during BUS → `mem_valid` = 0 immediately and no `rsp_valid`.
